// File: rtl/edge_detector_bank.sv
// Multi-channel synchroniser, debouncer and edge detector with mode-filtered event pulses.
// Define EDGE_DETECTOR_STICKY_EN to add sticky pending flags, per-channel clear and irq.
module edge_detector_bank #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   raw_input,
  input  logic [2*WIDTH-1:0] mode,
  output logic [WIDTH-1:0]   level,
  output logic [WIDTH-1:0]   rising,
  output logic [WIDTH-1:0]   falling,
  output logic [WIDTH-1:0]   edge_pulse
`ifdef EDGE_DETECTOR_STICKY_EN
  ,
  output logic [WIDTH-1:0]   pending,
  input  logic [WIDTH-1:0]   clear,
  output logic               irq
`endif
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] s_out;

  always_comb begin
    sync_d[0] = raw_input;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
    end
  end

  assign s_out = sync_q[SYNC_STAGES-1];

  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] level_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_comb begin
        level_d = s_out;
      end
    end else begin : g_deb
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt_q [WIDTH];
      logic [CW-1:0] cnt_d [WIDTH];

      // a differing run must reach DEBOUNCE_CYCLES cycles to be accepted
      always_comb begin
        level_d = level_q;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_d[i] = '0;
          if (s_out[i] != level_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
              level_d[i] = s_out[i];
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    prev_d = level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      prev_q  <= '0;
    end else begin
      level_q <= level_d;
      prev_q  <= prev_d;
    end
  end

  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;
  logic [WIDTH-1:0] evt_w;

  always_comb begin
    rise_w = level_q & ~prev_q;
    fall_w = ~level_q & prev_q;
    for (int i = 0; i < WIDTH; i++) begin
      evt_w[i] = (rise_w[i] & mode[2*i])
               | (fall_w[i] & mode[2*i+1]);
    end
  end

  assign level      = level_q;
  assign rising     = rise_w;
  assign falling    = fall_w;
  assign edge_pulse = evt_w;

`ifdef EDGE_DETECTOR_STICKY_EN
  logic [WIDTH-1:0] pending_q;
  logic [WIDTH-1:0] pending_d;

  // a new event outranks a same-cycle clear
  always_comb begin
    pending_d = (pending_q & ~clear) | evt_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;
  assign irq     = |pending_q;
`endif

endmodule

// File: tb/tb_edge_detector_bank.sv
// Bench for edge_detector_bank: run-length model compared every cycle,
// plus directed literal checks; second instance exercises the debounce bypass.
module tb_edge_detector_bank;

  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  raw = '0;
  logic [W-1:0]  raw_b = '0;
  logic [2*W-1:0] mode = 16'h5555;
  logic [W-1:0]  clear = '0;

  logic [W-1:0]  level, rising, falling, edge_pulse;
  logic [W-1:0]  level_b, rising_b, falling_b, edge_b;
`ifdef EDGE_DETECTOR_STICKY_EN
  logic [W-1:0]  pending, pending_b;
  logic          irq, irq_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  edge_detector_bank #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .raw_input(raw), .mode(mode),
    .level(level), .rising(rising), .falling(falling),
    .edge_pulse(edge_pulse)
`ifdef EDGE_DETECTOR_STICKY_EN
    , .pending(pending), .clear(clear), .irq(irq)
`endif
  );

  edge_detector_bank #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst(rst), .raw_input(raw_b), .mode(mode),
    .level(level_b), .rising(rising_b), .falling(falling_b),
    .edge_pulse(edge_b)
`ifdef EDGE_DETECTOR_STICKY_EN
    , .pending(pending_b), .clear(clear), .irq(irq_b)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: raw delayed SYNC edges; level accepts a value after DEB
  // consecutive differing samples; pulses come from level history.
  logic [W-1:0] m_hist [SYNC];
  int           m_run  [W];
  logic [W-1:0] m_lvl, m_prv, m_pend, m_s, m_ep;

  function automatic logic [W-1:0] filt(input logic [W-1:0] r,
                                        input logic [W-1:0] f,
                                        input logic [2*W-1:0] md);
    logic [W-1:0] e;
    for (int i = 0; i < W; i++) begin
      e[i] = (r[i] && md[2*i]) || (f[i] && md[2*i+1]);
    end
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      m_lvl  = '0;
      m_prv  = '0;
      m_pend = '0;
    end else begin
      m_s  = m_hist[SYNC-1];
      m_ep = filt(m_lvl & ~m_prv, ~m_lvl & m_prv, mode);
      m_pend = (m_pend & ~clear) | m_ep;
      m_prv = m_lvl;
      for (int i = 0; i < W; i++) begin
        if (m_s[i] != m_lvl[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= DEB) begin
            m_lvl[i] = m_s[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      for (int k = SYNC-1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = raw;
    end
  end

  always @(negedge clk) begin
    chk("model_level", 32'(level), 32'(m_lvl));
    chk("model_rising", 32'(rising), 32'(m_lvl & ~m_prv));
    chk("model_falling", 32'(falling), 32'(~m_lvl & m_prv));
    chk("model_edge", 32'(edge_pulse),
        32'(filt(m_lvl & ~m_prv, ~m_lvl & m_prv, mode)));
    chk("rise_fall_excl", 32'(rising & falling), 32'h0);
`ifdef EDGE_DETECTOR_STICKY_EN
    chk("model_pending", 32'(pending), 32'(m_pend));
    chk("model_irq", 32'(irq), 32'(|m_pend));
`endif
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(3);
    chk("reset_level", 32'(level), 32'h0);
    chk("reset_pulses", 32'({rising, falling, edge_pulse}), 32'h0);
    chk("reset_level_b", 32'(level_b), 32'h0);
    rst = 1'b0;
    step(2);

    // single rising edge on ch0
    raw[0] = 1'b1;
    step(5);
    chk("t1_level_early", 32'(level), 32'h0);
    step(1);
    chk("t1_level", 32'(level), 32'h01);
    chk("t1_rising", 32'(rising), 32'h01);
    chk("t1_edge", 32'(edge_pulse), 32'h01);
    step(1);
    chk("t1_rising_gone", 32'(rising), 32'h0);
    chk("t1_falling", 32'(falling), 32'h0);

    // 3-cycle glitch on ch3 is rejected
    raw[3] = 1'b1;
    step(3);
    raw[3] = 1'b0;
    step(10);
    chk("t2_level", 32'(level), 32'h01);

    // falling-only mode on ch2
    mode = 16'h5565;
    raw[2] = 1'b1;
    step(6);
    chk("t3_rising", 32'(rising), 32'h04);
    chk("t3_edge_rise", 32'(edge_pulse), 32'h0);
    step(3);
    raw[2] = 1'b0;
    step(6);
    chk("t3_falling", 32'(falling), 32'h04);
    chk("t3_edge_fall", 32'(edge_pulse), 32'h04);
    step(2);

    // debounce bypass, all channels at once
    raw_b = 8'hFF;
    step(2);
    chk("t4_rising_early", 32'(rising_b), 32'h0);
    step(1);
    chk("t4_rising", 32'(rising_b), 32'hFF);
    step(1);
    chk("t4_rising_gone", 32'(rising_b), 32'h0);
    chk("t4_level", 32'(level_b), 32'hFF);

    // reset in the middle of a debounce run
    raw = 8'h00;
    step(10);
    raw = 8'hFF;
    step(2);
    #2 rst = 1'b1;
    #1;
    chk("t5_level_rst", 32'(level), 32'h0);
    chk("t5_pulse_rst", 32'({rising, falling, edge_pulse}), 32'h0);
    chk("t5_level_b_rst", 32'(level_b), 32'h0);
    step(3);
    rst = 1'b0;
    step(3);
    chk("t5_rising_b", 32'(rising_b), 32'hFF);
    step(2);
    chk("t5_rising_early", 32'(rising), 32'h0);
    step(1);
    chk("t5_rising", 32'(rising), 32'hFF);
    chk("t5_edge", 32'(edge_pulse), 32'hFB);
    step(2);

`ifdef EDGE_DETECTOR_STICKY_EN
    clear = 8'hFF;
    step(1);
    clear = 8'h00;
    raw[1] = 1'b0;
    step(10);
    clear = 8'hFF;
    step(1);
    clear = 8'h00;
    chk("t6_pending_clr", 32'({irq, pending}), 32'h0);
    raw[1] = 1'b1;
    step(6);
    clear[1] = 1'b1;
    step(1);
    clear[1] = 1'b0;
    chk("t6_pending_set", 32'(pending), 32'h02);
    chk("t6_irq_set", 32'(irq), 32'h1);
    step(1);
    clear[1] = 1'b1;
    step(1);
    clear[1] = 1'b0;
    chk("t6_pending_clr2", 32'(pending), 32'h0);
    chk("t6_irq_clr", 32'(irq), 32'h0);
    step(2);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
